// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment indices, active-high glyphs and
// the code-to-glyph decode used by every digit of the HEX display.
package seg7_pkg;

  // Segment positions inside a [0:6] word, a..g.
  localparam int SEG_A    = 0;
  localparam int SEG_B    = 1;
  localparam int SEG_C    = 2;
  localparam int SEG_D    = 3;
  localparam int SEG_E    = 4;
  localparam int SEG_F    = 5;
  localparam int SEG_G    = 6;
  localparam int NUM_SEGS = 7;

  // Glyph word, element 0 is segment a, element 6 is segment g; 1 = lit.
  typedef logic [0:NUM_SEGS-1] glyph_t;

  //                                  abcdefg
  localparam glyph_t GLYPH_0   = 7'b1111110;
  localparam glyph_t GLYPH_1   = 7'b0110000;
  localparam glyph_t GLYPH_2   = 7'b1101101;
  localparam glyph_t GLYPH_3   = 7'b1111001;
  localparam glyph_t GLYPH_4   = 7'b0110011;
  localparam glyph_t GLYPH_5   = 7'b1011011;
  localparam glyph_t GLYPH_6   = 7'b1011111;
  localparam glyph_t GLYPH_7   = 7'b1110000;
  localparam glyph_t GLYPH_8   = 7'b1111111;
  localparam glyph_t GLYPH_9   = 7'b1111011;
  localparam glyph_t GLYPH_A   = 7'b1110111;
  localparam glyph_t GLYPH_B   = 7'b0011111;
  localparam glyph_t GLYPH_C   = 7'b1001110;
  localparam glyph_t GLYPH_D   = 7'b0111101;
  localparam glyph_t GLYPH_E   = 7'b1001111;
  localparam glyph_t GLYPH_F   = 7'b1000111;
  localparam glyph_t GLYPH_OFF = 7'b0000000;

  // Map a 4-bit code to its active-high glyph. Codes above 9 only show a
  // letter when hex_mode is set; otherwise the digit goes dark.
  function automatic glyph_t decode_glyph(input logic [3:0] code,
                                          input logic       hex_mode);
    glyph_t g;
    g = GLYPH_OFF;
    case (code)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = hex_mode ? GLYPH_A : GLYPH_OFF;
      4'hB: g = hex_mode ? GLYPH_B : GLYPH_OFF;
      4'hC: g = hex_mode ? GLYPH_C : GLYPH_OFF;
      4'hD: g = hex_mode ? GLYPH_D : GLYPH_OFF;
      4'hE: g = hex_mode ? GLYPH_E : GLYPH_OFF;
      4'hF: g = hex_mode ? GLYPH_F : GLYPH_OFF;
      default: g = GLYPH_OFF;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd_7seg.sv
// Registered 4-bit to seven-segment decoder for one HEX display digit.
// Decoding is done active-high; board polarity is applied just before the
// output register so reset, blank and glyphs all share the same inversion.
module bcd_7seg
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_MODE   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      bcd,
  input  logic            blank,
  output logic [0:6]      seg
);

  // All segments dark, expressed in output polarity.
  localparam logic [0:6] SEG_ALL_OFF = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

  glyph_t     glyph_next;
  logic [0:6] seg_next;
  logic [0:6] seg_reg;

  // Blank overrides the code; everything else goes through the shared decode.
  always_comb begin
    glyph_next = GLYPH_OFF;
    if (blank) begin
      glyph_next = GLYPH_OFF;
    end else begin
      glyph_next = decode_glyph(bcd, HEX_MODE);
    end
  end

  // Per-segment polarity: a lit segment drives 0 on an active-low board.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEGS; gi++) begin : g_polarity
      assign seg_next[gi] = glyph_next[gi] ^ ACTIVE_LOW;
    end
  endgenerate

  // Output register; reset wins over any input on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg <= SEG_ALL_OFF;
    end else begin
      seg_reg <= seg_next;
    end
  end

  assign seg = seg_reg;

endmodule

// File: tb/tb_bcd_7seg.sv
// Self-checking bench for bcd_7seg. Three instances share the same inputs:
// board default (active-low, blank 10..15), hex mode, and active-high.
module tb_bcd_7seg;

  logic       clk;
  logic       rst;
  logic [3:0] bcd;
  logic       blank;
  logic [0:6] seg_def;
  logic [0:6] seg_hex;
  logic [0:6] seg_ah;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [0:6] e_def;
    logic [0:6] e_hex;
    logic [0:6] e_ah;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       prev_exp;
  bit         have_prev;
  logic [0:6] low_tab[16];

  bcd_7seg #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) u_def (
    .clk(clk), .rst(rst), .bcd(bcd), .blank(blank), .seg(seg_def));
  bcd_7seg #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) u_hex (
    .clk(clk), .rst(rst), .bcd(bcd), .blank(blank), .seg(seg_hex));
  bcd_7seg #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) u_ah (
    .clk(clk), .rst(rst), .bcd(bcd), .blank(blank), .seg(seg_ah));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: active-low words written straight from the segment table.
  function automatic logic [0:6] model(input logic r, input logic b,
                                       input logic [3:0] code,
                                       input bit al, input bit hex);
    logic [0:6] w;
    if (r || b || (code > 4'd9 && !hex)) w = 7'b1111111;
    else w = low_tab[code];
    return al ? w : ~w;
  endfunction

  task automatic check_val(input string tag, input logic [0:6] got,
                           input logic [0:6] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, confirm the output holds until the edge,
  // then pop the scoreboard once the register has captured.
  task automatic step(input logic r, input logic b, input logic [3:0] code,
                      input string tag);
    exp_t e;
    exp_t got_exp;
    @(negedge clk);
    rst   = r;
    blank = b;
    bcd   = code;
    e.e_def = model(r, b, code, 1'b1, 1'b0);
    e.e_hex = model(r, b, code, 1'b1, 1'b1);
    e.e_ah  = model(r, b, code, 1'b0, 1'b0);
    sb_q.push_back(e);
    #1;
    if (have_prev) begin
      check_val({tag, "_hold_def"}, seg_def, prev_exp.e_def);
      check_val({tag, "_hold_ah"},  seg_ah,  prev_exp.e_ah);
    end
    @(posedge clk);
    #1;
    got_exp = sb_q.pop_front();
    check_val({tag, "_def"}, seg_def, got_exp.e_def);
    check_val({tag, "_hex"}, seg_hex, got_exp.e_hex);
    check_val({tag, "_ah"},  seg_ah,  got_exp.e_ah);
    $display("[TB] %s rst=%0b blank=%0b bcd=%0d seg_def=%b seg_hex=%b seg_ah=%b",
             tag, r, b, code, seg_def, seg_hex, seg_ah);
    prev_exp  = got_exp;
    have_prev = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    low_tab[0]  = 7'b0000001; low_tab[1]  = 7'b1001111;
    low_tab[2]  = 7'b0010010; low_tab[3]  = 7'b0000110;
    low_tab[4]  = 7'b1001100; low_tab[5]  = 7'b0100100;
    low_tab[6]  = 7'b0100000; low_tab[7]  = 7'b0001111;
    low_tab[8]  = 7'b0000000; low_tab[9]  = 7'b0000100;
    low_tab[10] = 7'b0001000; low_tab[11] = 7'b1100000;
    low_tab[12] = 7'b0110001; low_tab[13] = 7'b1000010;
    low_tab[14] = 7'b0110000; low_tab[15] = 7'b0111000;
    tests_run    = 0;
    tests_failed = 0;
    have_prev    = 1'b0;
    rst   = 1'b1;
    blank = 1'b0;
    bcd   = 4'd8;

    // Reset held two cycles, then release shows an 8 (all segments lit).
    step(1'b1, 1'b0, 4'd8, "reset0");
    step(1'b1, 1'b0, 4'd8, "reset1");
    step(1'b0, 1'b0, 4'd8, "release");

    // Full code sweep covers decimal digits and the 10..15 boundary.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'(i), $sformatf("sweep%0d", i));
    end

    // Blank priority, then rst together with blank.
    step(1'b0, 1'b1, 4'd5, "blank5");
    step(1'b0, 1'b0, 4'd5, "unblank5");
    step(1'b1, 1'b1, 4'd5, "rst_blank");
    step(1'b0, 1'b0, 4'd1, "one");

    // 4 -> 7 transition with hold check before the edge.
    step(1'b0, 1'b0, 4'd4, "lat4");
    step(1'b0, 1'b0, 4'd7, "lat7");

    // Mid-operation reset takes effect on the same edge.
    step(1'b1, 1'b0, 4'd3, "midrst");

    // Back-to-back random traffic.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
